clint_rd_arbiter: RTL and testbench
===================================

Name: clint_rd_arbiter

Overview:
Two-requester read arbiter in front of the CLINT AXI read slave; shares the single read port between the instruction-fetch side (m0) and the load/store side (m1).
Converts each requester's simple valid/ready read request into a single-beat AXI read (len 0, size 8 bytes, INCR) and routes the R beat back to the granted requester.
Fair round-robin; one outstanding transaction at a time.

Parameters:
M0_ID, 4'd0, AXI ARID driven for m0 transactions
M1_ID, 4'd1, AXI ARID driven for m1 transactions

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m0_req_valid  in  1  m0 read request
m0_req_ready  out  1  m0 request accepted this cycle
m0_req_addr  in  64  m0 read address
m0_resp_valid  out  1  m0 read data valid
m0_resp_ready  in  1  m0 can take data
m0_resp_data  out  64  m0 read data
m0_resp_err  out  1  m0 error (RRESP≠0 or RID mismatch)
m1_req_valid / m1_req_ready / m1_req_addr / m1_resp_valid / m1_resp_ready / m1_resp_data / m1_resp_err  same as m0, for m1
axi_ar_id  out  4  M0_ID or M1_ID of granted requester
axi_ar_addr  out  64  latched request address
axi_ar_len  out  8  constant 8'd0
axi_ar_size  out  3  constant 3'b011
axi_ar_burst  out  2  constant 2'b01
axi_ar_valid  out  1  AR valid
axi_ar_ready  in  1  AR ready
axi_r_id  in  4  R id
axi_r_data  in  64  R data
axi_r_resp  in  2  R response
axi_r_last  in  1  R last
axi_r_valid  in  1  R valid
axi_r_ready  out  1  R ready

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset (async, rst=1): state IDLE, grant=m0, rr pointer prefers m0, latched addr=0; all outputs 0 except constant len/size/burst.
- IDLE: if any req_valid, choose winner: only one valid → it; both → the one not served last (pointer). Winner's req_ready=1 combinationally that cycle; loser's req_ready=0. Latch addr and grant; go ADDR next cycle. No valid → stay.
- ADDR: axi_ar_valid=1, ar_addr/ar_id stable until handshake. On ar_valid&ar_ready → DATA. No new request accepted (both req_ready=0).
- DATA: axi_r_ready = granted requester's resp_ready; granted resp_valid = axi_r_valid; resp_data = axi_r_data; resp_err = (r_resp≠2'b00)|(r_id≠granted ID). Non-granted resp_valid=0, resp_data=0, resp_err=0.
- On R handshake with r_last=1: pointer := granted requester, → IDLE. R handshake with r_last=0: forward beat, stay DATA.
- Latency: request accepted cycle T → ar_valid at T+1; earliest resp at T+2 if slave zero-wait.
- Back-to-back: IDLE for exactly one cycle between transactions; pending other requester wins next if valid (alternation under continuous contention).
- req_valid dropped after acceptance: transaction completes regardless.
- r_valid in IDLE/ADDR: ignored, r_ready=0.
- Reset mid-transaction: immediate return to IDLE, ar_valid/r_ready/resp_valid drop asynchronously; in-flight slave beat discarded.

Test Plan:
- m0 only, addr 64'h0200_BFF8, slave ARREADY=1, R data 64'h1234, id 0 → m0_req_ready at T, ar_valid T+1 with id 4'd0/len 0/size 3/burst 1, m0_resp_data 64'h1234, err 0.
- m0 and m1 valid continuously from reset, 4 transactions → grant order m0,m1,m0,m1; ar_id 0,1,0,1.
- m1 granted, slave holds ARREADY=0 for 3 cycles → ar_addr/ar_id stable, no req_ready to m0 meanwhile.
- m1 resp_ready=0 for 2 cycles with r_valid=1 → axi_r_ready=0, state stays DATA, data delivered on cycle ready rises.
- R with r_resp=2'b10, or r_id=4'd1 on m0 grant → m0_resp_err=1, FSM returns IDLE.
- rst asserted in ADDR → ar_valid=0 same cycle, state IDLE, next grant with both valid goes to m0.

Source files
------------

// File: rtl/clint_rd_arbiter.sv
// Round-robin arbiter sharing the CLINT AXI read port between fetch (m0) and load/store (m1).
// One single-beat read in flight at a time; the R beat is routed back to the granted requester.
module clint_rd_arbiter #(
  parameter logic [3:0] M0_ID = 4'd0,
  parameter logic [3:0] M1_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [63:0] m0_req_addr,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [63:0] m0_resp_data,
  output logic        m0_resp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [63:0] m1_req_addr,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [63:0] m1_resp_data,
  output logic        m1_resp_err,
  output logic [3:0]  axi_ar_id,
  output logic [63:0] axi_ar_addr,
  output logic [7:0]  axi_ar_len,
  output logic [2:0]  axi_ar_size,
  output logic [1:0]  axi_ar_burst,
  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  input  logic [3:0]  axi_r_id,
  input  logic [63:0] axi_r_data,
  input  logic [1:0]  axi_r_resp,
  input  logic        axi_r_last,
  input  logic        axi_r_valid,
  output logic        axi_r_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;   // 0 = m0, 1 = m1
  logic        prio_q, prio_d;     // requester preferred when both are valid
  logic [63:0] addr_q, addr_d;
  logic        win;
  logic        r_err;
  logic [3:0]  grant_id;

  assign grant_id     = grant_q ? M1_ID : M0_ID;
  assign axi_ar_id    = grant_id;
  assign axi_ar_addr  = addr_q;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = 3'b011;
  assign axi_ar_burst = 2'b01;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_d        = prio_q;
    addr_d        = addr_q;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m0_resp_data  = 64'd0;
    m0_resp_err   = 1'b0;
    m1_resp_valid = 1'b0;
    m1_resp_data  = 64'd0;
    m1_resp_err   = 1'b0;
    axi_ar_valid  = 1'b0;
    axi_r_ready   = 1'b0;
    win           = (m0_req_valid && m1_req_valid) ? prio_q : m1_req_valid;
    r_err         = (axi_r_resp != 2'b00) || (axi_r_id != grant_id);

    case (state_q)
      ST_IDLE: begin
        if (!rst && (m0_req_valid || m1_req_valid)) begin
          m0_req_ready = !win;
          m1_req_ready = win;
          grant_d      = win;
          addr_d       = win ? m1_req_addr : m0_req_addr;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        axi_r_ready = grant_q ? m1_resp_ready : m0_resp_ready;
        if (grant_q) begin
          m1_resp_valid = axi_r_valid;
          m1_resp_data  = axi_r_data;
          m1_resp_err   = r_err;
        end else begin
          m0_resp_valid = axi_r_valid;
          m0_resp_data  = axi_r_data;
          m0_resp_err   = r_err;
        end
        // Only the final beat releases the port and hands priority to the other side.
        if (axi_r_valid && axi_r_ready && axi_r_last) begin
          prio_d  = !grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_clint_rd_arbiter.sv
// Bench for clint_rd_arbiter: directed cases plus randomized traffic against a transaction-level model.
module tb_clint_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready, m0_resp_err;
  logic [63:0] m0_req_addr, m0_resp_data;
  logic        m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready, m1_resp_err;
  logic [63:0] m1_req_addr, m1_resp_data;
  logic [3:0]  axi_ar_id, axi_r_id;
  logic [63:0] axi_ar_addr, axi_r_data;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst, axi_r_resp;
  logic        axi_ar_valid, axi_ar_ready, axi_r_last, axi_r_valid, axi_r_ready;

  clint_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_resp_data(m0_resp_data), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_resp_data(m1_resp_data), .m1_resp_err(m1_resp_err),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Reference model: whether a read is owned, by whom, and whether its address is still unsent.
  bit          busy, in_addr, cur, pref;
  logic [63:0] cur_addr;
  // Slave stimulus state.
  bit          s_have, multi_ok;
  int          s_beats;
  logic [3:0]  s_id, s_idx;
  logic [63:0] s_data;
  logic [1:0]  s_resp;
  logic [3:0]  obs_ids[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; in_addr = 0; cur = 0; pref = 0; s_have = 0; s_beats = 0;
  endtask

  task automatic slave_drive(input bit rnd);
    if (!rnd) begin
      axi_r_valid = s_have;
      axi_r_data  = s_data;
      axi_r_resp  = s_resp;
      axi_r_id    = s_id ^ s_idx;
      axi_r_last  = 1'b1;
    end else begin
      axi_r_valid = s_have ? ($urandom % 4 != 0) : ($urandom % 6 == 0);
      axi_r_data  = {$urandom, $urandom};
      axi_r_resp  = ($urandom % 5 == 0) ? 2'($urandom) : 2'b00;
      axi_r_id    = ($urandom % 6 == 0) ? 4'($urandom) : s_id;
      axi_r_last  = s_have ? (s_beats == 1) : 1'($urandom);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, advance model and slave, return at posedge+1.
  task automatic cyc();
    bit e0, e1, rr, err, arhs, rhs;
    logic [3:0] eid;
    @(negedge clk);
    arhs = axi_ar_valid && axi_ar_ready;
    rhs  = axi_r_valid && axi_r_ready;
    eid  = cur ? 4'd1 : 4'd0;
    if (!busy) begin
      e0 = m0_req_valid && (!m1_req_valid || !pref);
      e1 = m1_req_valid && (!m0_req_valid || pref);
      chk("idle_m0_req_ready", m0_req_ready, e0);
      chk("idle_m1_req_ready", m1_req_ready, e1);
      chk("idle_ar_valid", axi_ar_valid, 0);
      chk("idle_r_ready", axi_r_ready, 0);
      chk("idle_resp_valid", {m1_resp_valid, m0_resp_valid}, 0);
      if (e0 || e1) begin
        busy = 1; in_addr = 1; cur = e1;
        cur_addr = e1 ? m1_req_addr : m0_req_addr;
      end
    end else if (in_addr) begin
      chk("addr_req_ready", {m1_req_ready, m0_req_ready}, 0);
      chk("addr_ar_valid", axi_ar_valid, 1);
      chk("addr_ar_addr", axi_ar_addr, cur_addr);
      chk("addr_ar_id", axi_ar_id, eid);
      chk("addr_r_ready", axi_r_ready, 0);
      chk("addr_resp_valid", {m1_resp_valid, m0_resp_valid}, 0);
      if (axi_ar_ready) in_addr = 0;
    end else begin
      rr = cur ? m1_resp_ready : m0_resp_ready;
      chk("data_req_ready", {m1_req_ready, m0_req_ready}, 0);
      chk("data_ar_valid", axi_ar_valid, 0);
      chk("data_r_ready", axi_r_ready, rr);
      chk("data_resp_valid", {m1_resp_valid, m0_resp_valid},
          cur ? {axi_r_valid, 1'b0} : {1'b0, axi_r_valid});
      if (axi_r_valid) begin
        err = (axi_r_resp != 2'b00) || (axi_r_id != eid);
        chk("data_resp_data", cur ? m1_resp_data : m0_resp_data, axi_r_data);
        chk("data_resp_err", cur ? m1_resp_err : m0_resp_err, err);
        chk("data_other_zero", cur ? {m0_resp_err, m0_resp_data} : {m1_resp_err, m1_resp_data}, 0);
      end
      if (axi_r_valid && rr && axi_r_last) begin
        busy = 0; pref = !cur; done_cnt++;
      end
    end
    if (arhs) begin
      obs_ids.push_back(axi_ar_id);
      s_have = 1; s_id = axi_ar_id;
      s_beats = (multi_ok && ($urandom % 3 == 0)) ? 2 : 1;
    end
    if (rhs && s_have) begin
      s_beats--;
      if (s_beats == 0) s_have = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m0_req_valid = 0; m1_req_valid = 0;
    axi_ar_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    for (int i = 0; i < 200 && busy; i++) begin
      slave_drive(1);
      cyc();
    end
    chk("drain_idle", busy, 0);
  endtask

  // Single m0 read through the zero-wait directed slave, checking the T / T+1 / T+2 timeline.
  task automatic m0_single(input logic [63:0] addr, input logic exp_err);
    m0_req_valid = 1; m0_req_addr = addr; m1_req_valid = 0;
    axi_ar_ready = 1; m0_resp_ready = 1;
    slave_drive(0);
    #1 chk("t_accept", m0_req_ready, 1);
    cyc();
    m0_req_valid = 0;
    slave_drive(0);
    #1 chk("t1_ar", {axi_ar_valid, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst},
           {1'b1, 4'd0, 8'd0, 3'b011, 2'b01});
    chk("t1_addr", axi_ar_addr, addr);
    cyc();
    slave_drive(0);
    #1 chk("t2_resp", {m0_resp_valid, m0_resp_err}, {1'b1, exp_err});
    chk("t2_data", m0_resp_data, s_data);
    cyc();
    chk("t_done", busy, 0);
  endtask

  initial begin
    m0_req_valid = 0; m0_req_addr = 0; m0_resp_ready = 0;
    m1_req_valid = 0; m1_req_addr = 0; m1_resp_ready = 0;
    axi_ar_ready = 0; axi_r_id = 0; axi_r_data = 0; axi_r_resp = 0;
    axi_r_last = 0; axi_r_valid = 0;
    s_data = 0; s_resp = 0; s_idx = 0; s_id = 0; multi_ok = 0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_ar", {axi_ar_valid, axi_ar_id, axi_ar_addr}, 0);
    chk("rst_const", {axi_ar_len, axi_ar_size, axi_ar_burst}, {8'd0, 3'b011, 2'b01});
    chk("rst_r_ready", axi_r_ready, 0);
    chk("rst_m0", {m0_req_ready, m0_resp_valid, m0_resp_err, m0_resp_data}, 0);
    chk("rst_m1", {m1_req_ready, m1_resp_valid, m1_resp_err, m1_resp_data}, 0);
    rst = 0;

    // Continuous contention from reset alternates m0, m1, m0, m1.
    m0_req_valid = 1; m0_req_addr = 64'h100;
    m1_req_valid = 1; m1_req_addr = 64'h200;
    axi_ar_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
    s_data = 64'hCAFE; obs_ids.delete();
    repeat (12) begin
      slave_drive(0);
      cyc();
    end
    chk("alt_cnt", obs_ids.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("alt_id", (i < obs_ids.size()) ? obs_ids[i] : 4'hF, i % 2);
    drain();

    s_data = 64'h1234; s_resp = 2'b00; s_idx = 4'd0;
    m0_single(64'h0200_BFF8, 1'b0);
    s_data = 64'h55AA; s_idx = 4'd1;
    m0_single(64'h0200_4000, 1'b1);
    s_data = 64'h7777; s_idx = 4'd0; s_resp = 2'b10;
    m0_single(64'h0200_4008, 1'b1);
    s_resp = 2'b00;

    // m0 served last, so m1 wins here; reset while its address is pending.
    m0_req_valid = 1; m1_req_valid = 1; axi_ar_ready = 0;
    slave_drive(0);
    cyc();
    chk("rst_pre_ar_valid", axi_ar_valid, 1);
    rst = 1;
    #1;
    chk("rst_mid_drop", {axi_ar_valid, axi_r_ready, m0_resp_valid, m1_resp_valid}, 0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    slave_drive(0);
    #1 chk("rst_regrant", {m1_req_ready, m0_req_ready}, 2'b01);
    cyc();
    drain();

    multi_ok = 1;
    repeat (3000) begin
      m0_req_valid  = ($urandom % 3 != 0);
      m1_req_valid  = ($urandom % 3 != 0);
      m0_req_addr   = {$urandom, $urandom};
      m1_req_addr   = {$urandom, $urandom};
      axi_ar_ready  = ($urandom % 3 != 0);
      m0_resp_ready = ($urandom % 3 != 0);
      m1_resp_ready = ($urandom % 3 != 0);
      slave_drive(1);
      cyc();
    end
    drain();
    chk("progress", done_cnt > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
